fetch_stage: RTL

Instruction-fetch stage of the pipelined MIPS core. It owns the program counter and drives the combinational program ROM address. It also owns the IF/ID pipeline register that feeds the decode/control/register-file stage. It accepts stall (load-use hazard), flush, and redirect (branch/jump/jr resolved in MEM) requests, and halts cleanly on fetches outside program memory.

---
 rtl/fetch_stage.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the program ROM address and
// holds the IF/ID pipeline register. It halts on out-of-range fetches.
module fetch_stage #(
  parameter int unsigned MEMORY_DEPTH = 512,
  parameter logic [31:0] TEXT_BASE    = 32'h0040_0000,
  parameter logic [31:0] RESET_PC     = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  input  logic [31:0] ImemInstruction,
  output logic [31:0] ImemAddress,
  output logic [31:0] PCValue,
  output logic [31:0] ID_Instruction,
  output logic [31:0] ID_PC_4,
  output logic        ID_Valid,
  output logic [31:0] FetchCount,
  output logic        FetchError,
  output logic        Halted
);

  typedef enum logic {RUN, HALT} state_e;

  localparam logic [31:0] LAST_OFF = 32'(4 * MEMORY_DEPTH - 4);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] fcount_q, fcount_d;
  logic        ferr_q, ferr_d;

  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;
  logic        in_range;

  assign ImemAddress = pc_q - TEXT_BASE;
  assign pc_plus4    = pc_q + 32'd4;
  assign redirect_pc = RedirectTarget & ~32'h3;
  assign in_range    = (pc_q >= TEXT_BASE) && (ImemAddress <= LAST_OFF) &&
                       (pc_q[1:0] == 2'b00);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_instr_d = id_instr_q;
    id_pc4_d   = id_pc4_q;
    id_valid_d = id_valid_q;
    fcount_d   = fcount_q;
    ferr_d     = ferr_q;
    unique case (state_q)
      RUN: begin
        if (Redirect) begin
          pc_d       = redirect_pc;
          id_instr_d = '0;
          id_pc4_d   = '0;
          id_valid_d = 1'b0;
        end else if (Stall) begin
          if (Flush) begin
            id_instr_d = '0;
            id_pc4_d   = '0;
            id_valid_d = 1'b0;
          end
        end else if (!in_range) begin
          id_instr_d = '0;
          id_pc4_d   = '0;
          id_valid_d = 1'b0;
          ferr_d     = 1'b1;
          state_d    = HALT;
        end else begin
          // A flushed fetch still consumes its slot: PC and count advance.
          pc_d     = pc_plus4;
          fcount_d = fcount_q + 32'd1;
          if (Flush) begin
            id_instr_d = '0;
            id_pc4_d   = '0;
            id_valid_d = 1'b0;
          end else begin
            id_instr_d = ImemInstruction;
            id_pc4_d   = pc_plus4;
            id_valid_d = 1'b1;
          end
        end
      end
      HALT: begin
        id_instr_d = '0;
        id_pc4_d   = '0;
        id_valid_d = 1'b0;
        if (Redirect) begin
          pc_d    = redirect_pc;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      id_instr_q <= '0;
      id_pc4_q   <= '0;
      id_valid_q <= 1'b0;
      fcount_q   <= '0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_instr_q <= id_instr_d;
      id_pc4_q   <= id_pc4_d;
      id_valid_q <= id_valid_d;
      fcount_q   <= fcount_d;
      ferr_q     <= ferr_d;
    end
  end

  assign PCValue        = pc_q;
  assign ID_Instruction = id_instr_q;
  assign ID_PC_4        = id_pc4_q;
  assign ID_Valid       = id_valid_q;
  assign FetchCount     = fcount_q;
  assign FetchError     = ferr_q;
  assign Halted         = (state_q == HALT);

endmodule
